// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word, address-field and icache FSM state types
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  // Field split for the default 16-frame cache (IDX_W = 4).
  typedef struct packed {
    logic [25:0] tag;
    logic [3:0]  idx;
    logic [1:0]  bytoff;
  } icachef_t;
  typedef enum logic {IDLE, FETCH} icache_state_t;
endpackage

// File: rtl/icache_if.sv
// icache_if: fetch <-> icache <-> memory controller signal bundle
//   cache: icache side; fs: fetch stage; mc: memory controller
interface icache_if;
  import cpu_types_pkg::*;
  logic  imemREN, ihit, iREN, iwait;
  word_t imemaddr, imemload, iaddr, iload;
  modport cache(input imemREN, imemaddr, iwait, iload, output ihit, imemload, iREN, iaddr);
  modport fs(output imemREN, imemaddr, input ihit, imemload);
  modport mc(input iREN, iaddr, output iwait, iload);
endinterface

// File: rtl/icache.sv
// icache: direct-mapped single-word-block read-only instruction cache
//   CLK/RST: clock, sync active-high reset
//   imemREN/imemaddr -> ihit/imemload: fetch lookup, combinational hit
//   iREN/iaddr -> iwait/iload: word read to memory controller on miss
module icache
  import cpu_types_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  imemREN,
  input  word_t imemaddr,
  output logic  ihit,
  output word_t imemload,
  output logic  iREN,
  output word_t iaddr,
  input  logic  iwait,
  input  word_t iload
);
  localparam int TAG_W = 30 - IDX_W;
  localparam int FRAMES = 2 ** IDX_W;
  icache_state_t state;
  word_t miss_addr;
  logic [FRAMES-1:0] valid;
  logic [TAG_W-1:0] tags [FRAMES];
  word_t data [FRAMES];
  logic [IDX_W-1:0] idx, fidx;
  logic [TAG_W-1:0] tag, ftag;
  logic lookup, fill;
  assign idx = imemaddr[IDX_W+1:2];
  assign tag = imemaddr[31:IDX_W+2];
  assign fidx = miss_addr[IDX_W+1:2];
  assign ftag = miss_addr[31:IDX_W+2];
  assign lookup = state == IDLE && imemREN && valid[idx] && tags[idx] == tag;
  assign fill = state == FETCH && !iwait && !RST;
  assign ihit = lookup;
  assign imemload = lookup ? data[idx] : '0;
  assign iREN = state == FETCH;
  assign iaddr = miss_addr;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      valid <= '0;
      miss_addr <= '0;
    end else if (state == IDLE) begin
      if (imemREN && !lookup) begin
        miss_addr <= imemaddr & ~32'h3;
        state <= FETCH;
      end
    end else if (!iwait) begin
      valid[fidx] <= 1'b1;
      state <= IDLE;
    end
  end
  // Tag/data arrays carry no reset; valid bits alone gate their use.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tags[fidx] <= ftag;
      data[fidx] <= iload;
    end
  end
endmodule
